// File: rtl/pixel_plotter.sv
// pixel_plotter: buffers draw-engine pixels in a small FIFO and drains them to the VGA adapter write port.
// Optional macro PLOT_CLIP_EN: off-screen pixels are consumed unplotted and counted in dropped.
module pixel_plotter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned X_MAX = 160,
    parameter int unsigned Y_MAX = 120
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       in_last,
    input  logic       plot_en,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic       busy,
    output logic [7:0] dropped
);
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || X_MAX > 256 || Y_MAX > 128)
    begin : g_param_check
        $error("pixel_plotter: illegal parameter value");
    end

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] colour;
        logic          last;
    } pix_t;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    pix_t          mem_q [DEPTH];
    pix_t          mem_d [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] colour_q, colour_d;
    logic          plot_q, plot_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] dropped_q, dropped_d;

    logic full, empty, push, pop, clip;
    pix_t head;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign in_ready = resetn && !full;
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q[PW-1:0]];
    assign pop      = (state_q == IDLE) && !empty && plot_en;

`ifdef PLOT_CLIP_EN
    assign clip = (32'(head.x) >= X_MAX) || (32'(head.y) >= Y_MAX);
`else
    assign clip = 1'b0;
`endif

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        done_d    = 1'b0;
        dropped_d = dropped_q;

        if (push) begin
            mem_d[wr_ptr_q[PW-1:0]] = '{x: in_x, y: in_y, colour: in_colour, last: in_last};
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + (PW+1)'(1);
                    if (clip) begin
                        if (dropped_q != '1) dropped_d = dropped_q + DW'(1);
                    end else begin
                        x_d      = head.x;
                        y_d      = head.y;
                        colour_d = head.colour;
                        plot_d   = 1'b1;
                    end
                    if (head.last) state_d = WRITE;
                end
            end
            WRITE:   state_d = DONE;
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Registered view of busy, evaluated on the next-cycle state.
        busy_d = (wr_ptr_d != rd_ptr_d) || plot_d || (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign dropped = dropped_q;
endmodule
